// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; counts a fixed latency then commits.
// Optional `MD_MADD_EN enables madd/maddu/msub (ops 7-9) accumulating into HI/LO.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        latch;
  logic [31:0] hi_nx, lo_nx;
  logic        op_mul, op_div;

  always_comb begin
    op_mul = (md_op == 4'd1) || (md_op == 4'd2);
`ifdef MD_MADD_EN
    op_mul = op_mul || (md_op == 4'd7) || (md_op == 4'd8) || (md_op == 4'd9);
`endif
    op_div = (md_op == 4'd3) || (md_op == 4'd4);
  end

  assign busy  = (state != IDLE) || (md_start && (op_mul || op_div));
  assign stall = md_use_D && busy;

  // Products: low 64 bits of a sign/zero-extended multiply.
  logic [63:0] a_sx, b_sx, a_zx, b_zx, mul_s, mul_u, acc;
  assign a_sx  = {{32{a_q[31]}}, a_q};
  assign b_sx  = {{32{b_q[31]}}, b_q};
  assign a_zx  = {32'd0, a_q};
  assign b_zx  = {32'd0, b_q};
  assign mul_s = a_sx * b_sx;
  assign mul_u = a_zx * b_zx;
  assign acc   = {hi, lo};

  // Signed divide via magnitudes so INT_MIN / -1 needs no special path:
  // |quotient| = 2^31 with positive sign wraps to 32'h8000_0000, remainder 0.
  logic        b_zero, a_neg, b_neg;
  logic [31:0] b_safe, a_mag, b_mag, qu_mag, ru_mag, q_s, r_s, q_u, r_u;
  assign b_zero = (b_q == '0);
  assign b_safe = b_zero ? 32'd1 : b_q;
  assign a_neg  = a_q[31];
  assign b_neg  = b_safe[31];
  assign a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag  = b_neg ? (~b_safe + 32'd1) : b_safe;
  assign qu_mag = a_mag / b_mag;
  assign ru_mag = a_mag % b_mag;
  assign q_s    = (a_neg ^ b_neg) ? (~qu_mag + 32'd1) : qu_mag;
  assign r_s    = a_neg ? (~ru_mag + 32'd1) : ru_mag;
  assign q_u    = a_q / b_safe;
  assign r_u    = a_q % b_safe;

  logic [63:0] result;
  always_comb begin
    result = acc;
    case (op_q)
      4'd1: result = mul_s;
      4'd2: result = mul_u;
      4'd3: result = b_zero ? {a_q, 32'hFFFF_FFFF} : {r_s, q_s};
      4'd4: result = b_zero ? {a_q, 32'hFFFF_FFFF} : {r_u, q_u};
`ifdef MD_MADD_EN
      4'd7: result = acc + mul_s;
      4'd8: result = acc + mul_u;
      4'd9: result = acc - mul_s;
`endif
      default: result = acc;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = hi;
    lo_nx    = lo;
    latch    = 1'b0;
    case (state)
      IDLE: begin
        if (md_start) begin
          if (op_mul) begin
            state_nx = MUL;
            cnt_nx   = 4'(MULT_CYCLES);
            latch    = 1'b1;
          end else if (op_div) begin
            state_nx = DIV;
            cnt_nx   = 4'(DIV_CYCLES);
            latch    = 1'b1;
          end else if (md_op == 4'd5) begin
            hi_nx = rs_val;
          end else if (md_op == 4'd6) begin
            lo_nx = rs_val;
          end
        end
      end
      MUL, DIV: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx       = IDLE;
          {hi_nx, lo_nx} = result;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      if (latch) begin
        op_q <= md_op;
        a_q  <= rs_val;
        b_q  <= rt_val;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops on each accepted md_start and checks timing and results.
module tb_md_unit_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        md_start = 1'b0;
  logic [3:0]  md_op = '0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        md_use_D = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .md_start(md_start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int len);
    longint      sa, sb, qq, rr;
    logic [63:0] ps, pu, ac;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = 64'(sa * sb);
    pu = {32'd0, a} * {32'd0, b};
    ac = {m_hi, m_lo};
    len = 0;
    case (op)
      4'd1: begin {m_hi, m_lo} = ps; len = MC + 1; end
      4'd2: begin {m_hi, m_lo} = pu; len = MC + 1; end
      4'd3: begin
        len = DC + 1;
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin
          qq = sa / sb;
          rr = sa - qq * sb;
          m_lo = qq[31:0];
          m_hi = rr[31:0];
        end
      end
      4'd4: begin
        len = DC + 1;
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
`ifdef MD_MADD_EN
      4'd7: begin {m_hi, m_lo} = ac + ps; len = MC + 1; end
      4'd8: begin {m_hi, m_lo} = ac + pu; len = MC + 1; end
      4'd9: begin {m_hi, m_lo} = ac - ps; len = MC + 1; end
`endif
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic usd, input bit inject);
    int   len;
    exp_t e;
    bit   done;
    model(op, a, b, len);
    e.rst = 0; e.hi = m_hi; e.lo = m_lo; e.len = len;
    q.push_back(e);
    md_op = op; rs_val = a; rt_val = b; md_use_D = usd; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin done = 1; break; end
      md_start = (inject && i == 1);
      md_op    = md_start ? 4'd1 : 4'($urandom);
      rs_val   = $urandom;
      rt_val   = $urandom;
      @(posedge clk); #1;
    end
    md_start = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL busy_timeout: busy still %b after 40 cycles, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one scoreboard entry per md_start accepted in idle, or per reset.
  initial begin
    exp_t e;
    bit   aborted;
    forever begin
      @(negedge clk);
      if (q.size() == 0) continue;
      if (q[0].rst) begin
        if (!reset_n) begin
          e = q.pop_front();
          chk("reset_hilo", {hi, lo}, {e.hi, e.lo});
          chk("reset_busy", {busy, stall}, 2'b00);
        end
        continue;
      end
      if (!(md_start && reset_n)) continue;
      e = q.pop_front();
      chk("issue_busy", busy, (e.len > 0));
      chk("issue_stall", stall, md_use_D && (e.len > 0));
      aborted = 0;
      for (int i = 1; i < e.len; i++) begin
        @(negedge clk);
        if (!reset_n) begin aborted = 1; break; end
        chk("op_busy", busy, 1'b1);
        chk("op_stall", stall, md_use_D);
      end
      if (aborted) continue;
      @(negedge clk);
      if (!reset_n) continue;
      chk("done_busy", busy, 1'b0);
      chk("result_hilo", {hi, lo}, {e.hi, e.lo});
    end
  end

  initial begin
    exp_t r;
    int   len;
    r.rst = 1; r.hi = '0; r.lo = '0; r.len = 0;
    q.push_back(r);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
    issue(4'd4, 32'd100, 32'd7, 1'b1, 0);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    issue(4'd3, 32'd5, 32'd0, 1'b0, 0);
    issue(4'd4, 32'd9, 32'd0, 1'b1, 0);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    issue(4'd5, 32'h1234_5678, 32'd0, 1'b1, 0);
    issue(4'd1, 32'd7, 32'hFFFF_FFFF, 1'b1, 1);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    issue(4'd5, 32'd0, 32'd0, 1'b0, 0);
    issue(4'd6, 32'd10, 32'd0, 1'b0, 0);
    issue(4'd7, 32'd3, 32'd4, 1'b1, 0);
    issue(4'd9, 32'd100, 32'd2, 1'b0, 0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    issue(4'd12, 32'h5555_5555, 32'd1, 1'b1, 0);

    // Reset during a divide: HI/LO cleared and the pending result never lands.
    model(4'd3, 32'd1000, 32'd3, len);
    r.rst = 0; r.hi = m_hi; r.lo = m_lo; r.len = len;
    q.push_back(r);
    md_op = 4'd3; rs_val = 32'd1000; rt_val = 32'd3; md_use_D = 1'b0; md_start = 1'b1;
    @(posedge clk); #1 md_start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    r.rst = 1; r.hi = '0; r.lo = '0; r.len = 0;
    q.push_back(r);
    m_hi = '0; m_lo = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    issue(4'd0, 32'd0, 32'd0, 1'b0, 0);

    for (int n = 0; n < 60; n++)
      issue(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom), ($urandom_range(0, 3) == 0));

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
